// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD frame counter and its sequencing controller.
package axi_tdd_ng_pkg;

  // Frame counter state.
  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Armed   = 2'd1,
    Waiting = 2'd2,
    Running = 2'd3
  } state_t;

  // Sequencing controller state.
  typedef enum logic [1:0] {
    CtrlDisabled = 2'd0,
    CtrlArming   = 2'd1,
    CtrlActive   = 2'd2,
    CtrlStopping = 2'd3
  } ctrl_state_t;

  // Points at which a new configuration can be applied without cutting a frame short.
  function automatic logic cfg_safe(input ctrl_state_t cs, input state_t ts);
    return (cs == CtrlDisabled) || (ts == Idle) || (ts == Armed);
  endfunction

endpackage

// File: rtl/axi_tdd_ng_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a rising-edge detector.
// rise is high for one cycle, two cycles after the pin is first sampled high.
module axi_tdd_ng_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  // [0],[1] synchronizer stages, [2] delayed copy used for edge detection
  logic [2:0] sync_q;

  // Shift the pin through the synchronizer and edge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/axi_tdd_ng_ctrl.sv
// Sequencing controller in front of the TDD frame counter: owns the counter's enable and
// sync, shadows its timing configuration and arbitrates the internal, external and software
// sync sources. Define AXI_TDD_NG_SYNC_EXT_EN to build the external sync pin path.
module axi_tdd_ng_ctrl
  import axi_tdd_ng_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH    = 32,
  parameter int unsigned BURST_COUNT_WIDTH = 32,
  parameter int unsigned SYNC_COUNT_WIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sw_enable,
  input  logic [BURST_COUNT_WIDTH-1:0] cfg_burst_count,
  input  logic [REGISTER_WIDTH-1:0]    cfg_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    cfg_frame_length,
  input  logic                         cfg_update,
  input  logic                         sync_int_en,
  input  logic                         sync_ext_en,
  input  logic [SYNC_COUNT_WIDTH-1:0]  sync_period,
  input  logic                         sync_soft,
  input  logic                         sync_ext,
  input  state_t                       tdd_cstate,
  input  logic                         tdd_endof_frame,
  output logic                         tdd_enable,
  output logic                         tdd_sync,
  output logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  output logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  output logic                         cfg_pending,
  output logic                         sync_missed,
  output ctrl_state_t                  ctrl_state
);

  ctrl_state_t                  state_q;
  logic [SYNC_COUNT_WIDTH-1:0]  timer_q;
  logic [BURST_COUNT_WIDTH-1:0] pend_burst_q, shad_burst_q;
  logic [REGISTER_WIDTH-1:0]    pend_delay_q, shad_delay_q;
  logic [REGISTER_WIDTH-1:0]    pend_frame_q, shad_frame_q;
  logic                         pending_q;
  logic                         sync_q;
  logic                         missed_q;

  logic ext_rise;
  logic timer_term;
  logic sync_req;
  logic sync_ok;
  logic cfg_apply;

`ifdef AXI_TDD_NG_SYNC_EXT_EN
  logic ext_rise_raw;

  axi_tdd_ng_sync_edge i_sync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (sync_ext),
    .rise  (ext_rise_raw)
  );

  assign ext_rise = sync_ext_en & ext_rise_raw;
`else
  logic unused_ext;
  assign unused_ext = sync_ext ^ sync_ext_en;
  assign ext_rise   = 1'b0;
`endif

  // >= rather than == so a shrinking sync_period still wraps promptly
  assign timer_term = (state_q == CtrlActive) && sync_int_en && (sync_period != '0) &&
                      (timer_q >= sync_period - SYNC_COUNT_WIDTH'(1));

  assign sync_req  = timer_term | ext_rise | sync_soft;
  assign sync_ok   = (state_q == CtrlActive) && (tdd_cstate == Armed) && !pending_q;
  assign cfg_apply = pending_q && cfg_safe(state_q, tdd_cstate);

  // Controller FSM; a disable request wins over arming completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CtrlDisabled;
    end else begin
      case (state_q)
        CtrlDisabled: begin
          if (sw_enable) state_q <= CtrlArming;
        end
        CtrlArming: begin
          if (!sw_enable) begin
            state_q <= CtrlDisabled;
          end else if (tdd_cstate == Armed) begin
            state_q <= CtrlActive;
          end
        end
        CtrlActive: begin
          if (!sw_enable) begin
            state_q <= (tdd_cstate == Running) ? CtrlStopping : CtrlDisabled;
          end
        end
        default: begin
          if (tdd_endof_frame || (tdd_cstate != Running)) state_q <= CtrlDisabled;
        end
      endcase
    end
  end

  // Internal period timer; held at zero outside ACTIVE so it restarts on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if ((state_q != CtrlActive) || !sync_int_en || (sync_period == '0) || timer_term) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + SYNC_COUNT_WIDTH'(1);
    end
  end

  // Registered sync forward / drop indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      sync_q   <= sync_req && sync_ok;
      missed_q <= sync_req && !sync_ok && (state_q != CtrlDisabled);
    end
  end

  // Pending and shadow configuration; a new update in the copy cycle stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_burst_q <= '0;
      pend_delay_q <= '0;
      pend_frame_q <= '0;
      shad_burst_q <= '0;
      shad_delay_q <= '0;
      shad_frame_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (cfg_apply) begin
        shad_burst_q <= pend_burst_q;
        shad_delay_q <= pend_delay_q;
        shad_frame_q <= pend_frame_q;
      end
      if (cfg_update) begin
        pend_burst_q <= cfg_burst_count;
        pend_delay_q <= cfg_startup_delay;
        pend_frame_q <= cfg_frame_length;
        pending_q    <= 1'b1;
      end else if (cfg_apply) begin
        pending_q    <= 1'b0;
      end
    end
  end

  assign tdd_enable        = (state_q != CtrlDisabled);
  assign tdd_sync          = sync_q;
  assign sync_missed       = missed_q;
  assign cfg_pending       = pending_q;
  assign ctrl_state        = state_q;
  assign tdd_burst_count   = shad_burst_q;
  assign tdd_startup_delay = shad_delay_q;
  assign tdd_frame_length  = shad_frame_q;

endmodule

// File: tb/tb_axi_tdd_ng_ctrl.sv
// Self-checking bench for axi_tdd_ng_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural reference model.
`timescale 1ns/1ps
module tb_axi_tdd_ng_ctrl;
  import axi_tdd_ng_pkg::*;

  localparam int RW = 32;
  localparam int BW = 32;
  localparam int SW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          sw_enable;
  logic [BW-1:0] cfg_burst_count;
  logic [RW-1:0] cfg_startup_delay;
  logic [RW-1:0] cfg_frame_length;
  logic          cfg_update;
  logic          sync_int_en;
  logic          sync_ext_en;
  logic [SW-1:0] sync_period;
  logic          sync_soft;
  logic          sync_ext;
  state_t        tdd_cstate;
  logic          tdd_endof_frame;
  logic          tdd_enable;
  logic          tdd_sync;
  logic [BW-1:0] tdd_burst_count;
  logic [RW-1:0] tdd_startup_delay;
  logic [RW-1:0] tdd_frame_length;
  logic          cfg_pending;
  logic          sync_missed;
  ctrl_state_t   ctrl_state;

  always #5 clk = ~clk;

  axi_tdd_ng_ctrl #(
    .REGISTER_WIDTH    (RW),
    .BURST_COUNT_WIDTH (BW),
    .SYNC_COUNT_WIDTH  (SW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .sw_enable         (sw_enable),
    .cfg_burst_count   (cfg_burst_count),
    .cfg_startup_delay (cfg_startup_delay),
    .cfg_frame_length  (cfg_frame_length),
    .cfg_update        (cfg_update),
    .sync_int_en       (sync_int_en),
    .sync_ext_en       (sync_ext_en),
    .sync_period       (sync_period),
    .sync_soft         (sync_soft),
    .sync_ext          (sync_ext),
    .tdd_cstate        (tdd_cstate),
    .tdd_endof_frame   (tdd_endof_frame),
    .tdd_enable        (tdd_enable),
    .tdd_sync          (tdd_sync),
    .tdd_burst_count   (tdd_burst_count),
    .tdd_startup_delay (tdd_startup_delay),
    .tdd_frame_length  (tdd_frame_length),
    .cfg_pending       (cfg_pending),
    .sync_missed       (sync_missed),
    .ctrl_state        (ctrl_state)
  );

  // Reference model state
  ctrl_state_t     m_st;
  longint unsigned m_timer;     // cycles elapsed in the current internal period
  logic [BW-1:0]   m_pb, m_sb;
  logic [RW-1:0]   m_pd, m_sd, m_pf, m_sf;
  bit              m_pend, m_sync, m_miss;
  bit [2:0]        m_ext;       // sync_ext as sampled at the last three edges, [0] newest

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit act, term, ext_ev, req, ok, apply;
    if (reset) begin
      m_st = CtrlDisabled; m_timer = 0; m_pend = 0; m_sync = 0; m_miss = 0; m_ext = '0;
      m_pb = '0; m_pd = '0; m_pf = '0; m_sb = '0; m_sd = '0; m_sf = '0;
    end else begin
      act  = (m_st == CtrlActive);
      term = act && sync_int_en && (sync_period != 0) && (m_timer + 1 >= sync_period);
`ifdef AXI_TDD_NG_SYNC_EXT_EN
      ext_ev = sync_ext_en && m_ext[1] && !m_ext[2];
`else
      ext_ev = 1'b0;
`endif
      req    = term || ext_ev || sync_soft;
      ok     = act && (tdd_cstate == Armed) && !m_pend;
      m_sync = req && ok;
      m_miss = req && !ok && (m_st != CtrlDisabled);
      if (!act || !sync_int_en || sync_period == 0 || term) m_timer = 0;
      else m_timer++;
      apply = m_pend && (m_st == CtrlDisabled || tdd_cstate == Idle || tdd_cstate == Armed);
      if (apply) begin
        m_sb = m_pb; m_sd = m_pd; m_sf = m_pf;
      end
      if (cfg_update) begin
        m_pb = cfg_burst_count; m_pd = cfg_startup_delay; m_pf = cfg_frame_length; m_pend = 1;
      end else if (apply) begin
        m_pend = 0;
      end
      case (m_st)
        CtrlDisabled: if (sw_enable) m_st = CtrlArming;
        CtrlArming: begin
          if (!sw_enable) m_st = CtrlDisabled;
          else if (tdd_cstate == Armed) m_st = CtrlActive;
        end
        CtrlActive: if (!sw_enable) m_st = (tdd_cstate == Running) ? CtrlStopping : CtrlDisabled;
        default: if (tdd_endof_frame || tdd_cstate != Running) m_st = CtrlDisabled;
      endcase
      m_ext = {m_ext[1:0], sync_ext};
    end
  endtask

  task automatic check_all();
    check("tdd_enable", tdd_enable, m_st != CtrlDisabled);
    check("ctrl_state", ctrl_state, m_st);
    check("tdd_sync", tdd_sync, m_sync);
    check("sync_missed", sync_missed, m_miss);
    check("cfg_pending", cfg_pending, m_pend);
    check("burst_count", tdd_burst_count, m_sb);
    check("startup_delay", tdd_startup_delay, m_sd);
    check("frame_length", tdd_frame_length, m_sf);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  int n_sync;
  int first_at;

  initial begin
    reset = 1; sw_enable = 0; cfg_burst_count = '0; cfg_startup_delay = '0;
    cfg_frame_length = '0; cfg_update = 0; sync_int_en = 0; sync_ext_en = 0;
    sync_period = '0; sync_soft = 0; sync_ext = 0; tdd_cstate = Idle; tdd_endof_frame = 0;
    repeat (3) tick();
    check("rst_enable", tdd_enable, 1'b0);
    check("rst_state", ctrl_state, CtrlDisabled);
    reset = 0;

    // Enable and arm
    sw_enable = 1; tdd_cstate = Armed;
    tick(); tick();
    check("arm_active", ctrl_state, CtrlActive);

    // Software sync
    sync_soft = 1; tick(); sync_soft = 0;
    check("soft_sync", tdd_sync, 1'b1);
    tick();
    check("soft_sync_end", tdd_sync, 1'b0);

    // Internal timer, period 10 then 0
    sync_int_en = 1; sync_period = 10; n_sync = 0;
    repeat (30) begin tick(); n_sync += tdd_sync; end
    check("timer_p10", n_sync, 3);
    sync_period = 0; n_sync = 0;
    repeat (20) begin tick(); n_sync += tdd_sync; end
    check("timer_p0", n_sync, 0);
    sync_int_en = 0;

    // Graceful stop
    tdd_cstate = Running; sw_enable = 0; tick();
    check("stop_state", ctrl_state, CtrlStopping);
    tick();
    check("stop_enable", tdd_enable, 1'b1);
    tdd_endof_frame = 1; tick(); tdd_endof_frame = 0;
    check("stop_done", tdd_enable, 1'b0);

    // Config gating
    sw_enable = 1; tdd_cstate = Armed; tick(); tick();
    tdd_cstate = Running; tick();
    cfg_frame_length = 100; cfg_burst_count = 7; cfg_startup_delay = 3; cfg_update = 1;
    tick(); cfg_update = 0;
    check("cfg_held_pend", cfg_pending, 1'b1);
    check("cfg_held_frame", tdd_frame_length, 0);
    tdd_cstate = Armed; sync_soft = 1; tick(); sync_soft = 0;
    check("cfg_applied", tdd_frame_length, 100);
    check("cfg_cleared", cfg_pending, 1'b0);
    check("cfg_sync_miss", sync_missed, 1'b1);

    // Dropped sync while running
    tdd_cstate = Running; sync_soft = 1; tick(); sync_soft = 0;
    check("drop_sync", tdd_sync, 1'b0);
    check("drop_miss", sync_missed, 1'b1);
    tick();
    check("drop_miss_end", sync_missed, 1'b0);

    // External sync held high
    tdd_cstate = Armed; sync_ext_en = 1; sync_ext = 1; n_sync = 0; first_at = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (tdd_sync) begin
        n_sync++;
        if (first_at == 0) first_at = i;
      end
    end
`ifdef AXI_TDD_NG_SYNC_EXT_EN
    check("ext_count", n_sync, 1);
    check("ext_latency", first_at, 3);
`else
    check("ext_count", n_sync, 0);
`endif
    sync_ext = 0; sync_ext_en = 0;

    // Reset mid-frame discards pending config
    tdd_cstate = Running; cfg_frame_length = 55; cfg_update = 1; tick(); cfg_update = 0;
    check("rst_mid_pend", cfg_pending, 1'b1);
    reset = 1; tick(); reset = 0;
    check("rst_mid_enable", tdd_enable, 1'b0);
    check("rst_mid_pend_clr", cfg_pending, 1'b0);
    check("rst_mid_frame", tdd_frame_length, 0);

    // Random stimulus
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(299, 0) == 0);
      if ($urandom_range(19, 0) == 0) sw_enable = ~sw_enable;
      if ($urandom_range(3, 0) == 0) tdd_cstate = state_t'($urandom_range(3, 0));
      tdd_endof_frame = ($urandom_range(7, 0) == 0);
      sync_soft       = ($urandom_range(7, 0) == 0);
      cfg_update      = ($urandom_range(9, 0) == 0);
      cfg_burst_count   = $urandom;
      cfg_startup_delay = $urandom;
      cfg_frame_length  = $urandom;
      if ($urandom_range(3, 0) == 0) sync_ext = ~sync_ext;
      if ($urandom_range(29, 0) == 0) sync_ext_en = ~sync_ext_en;
      if ($urandom_range(29, 0) == 0) sync_int_en = ~sync_int_en;
      if ($urandom_range(49, 0) == 0) begin
        case ($urandom_range(4, 0))
          0: sync_period = 0;
          1: sync_period = 1;
          2: sync_period = 2;
          3: sync_period = 5;
          default: sync_period = 10;
        endcase
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/axi_tdd_ng_ctrl.md
# axi_tdd_ng_ctrl

Sequencing controller placed in front of the TDD frame counter. It owns the counter's enable and sync inputs and holds its timing configuration. It arbitrates three sync sources: internal periodic timer, external pin and software pulse. Configuration updates and disable requests are applied only at safe points so a frame is never cut short.

## Interface
- REGISTER_WIDTH, 32, width of startup delay / frame length
- BURST_COUNT_WIDTH, 32, width of burst count
- SYNC_COUNT_WIDTH, 64, width of internal sync period timer
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- sw_enable  input  1  software enable level
- cfg_burst_count  input  BURST_COUNT_WIDTH  requested burst count
- cfg_startup_delay  input  REGISTER_WIDTH  requested startup delay
- cfg_frame_length  input  REGISTER_WIDTH  requested frame length
- cfg_update  input  1  one-cycle pulse: latch cfg_* as pending
- sync_int_en / sync_ext_en  input  1  enable internal / external sync source
- sync_period  input  SYNC_COUNT_WIDTH  internal sync period in cycles; 0 = no internal syncs
- sync_soft  input  1  one-cycle software sync pulse
- sync_ext  input  1  asynchronous external sync pin
- tdd_cstate  input  axi_tdd_ng_pkg::state_t  counter state
- tdd_endof_frame  input  1  counter end-of-frame flag
- tdd_enable  output  1  counter enable
- tdd_sync  output  1  one-cycle sync pulse to counter
- tdd_burst_count / tdd_startup_delay / tdd_frame_length  output  as cfg_*  active (shadow) configuration
- cfg_pending  output  1  update latched, not yet applied
- sync_missed  output  1  one-cycle pulse: sync request dropped
- ctrl_state  output  axi_tdd_ng_pkg::ctrl_state_t  controller state

## Operation
- Reset values: tdd_enable 0, tdd_sync 0, shadows 0, cfg_pending 0, sync_missed 0, ctrl_state DISABLED, timer 0.
- States:
  - DISABLED: sw_enable=1 → ARMING.
  - ARMING: tdd_cstate==ARMED → ACTIVE; sw_enable=0 → DISABLED.
  - ACTIVE: sw_enable=0 → STOPPING if tdd_cstate==RUNNING, else DISABLED.
  - STOPPING: tdd_endof_frame=1 or tdd_cstate!=RUNNING → DISABLED. sw_enable is ignored in STOPPING.
- tdd_enable = (ctrl_state != DISABLED), decoded from the state register.
- Config:
  - cfg_update latches cfg_* into pending registers and sets cfg_pending.
  - Pending is copied to the shadows when ctrl_state==DISABLED or tdd_cstate is IDLE/ARMED; cfg_pending clears in the same cycle.
  - A cfg_update arriving during the copy cycle overwrites pending and keeps cfg_pending=1.
- Sync request = (sync_int_en & timer terminal) | (sync_ext_en & ext rising edge) | sync_soft.
- A request is forwarded only when ctrl_state==ACTIVE, tdd_cstate==ARMED and cfg_pending==0. Otherwise it is dropped and sync_missed pulses, but only while ctrl_state!=DISABLED.
- Simultaneous requests from several sources produce one tdd_sync.
- Internal timer:
  - Clears on entry to ACTIVE and on terminal count (sync_period-1).
  - Counts while ACTIVE, wraps modulo sync_period.
  - Holds 0 when sync_period==0 or sync_int_en==0.

## Timing
- tdd_sync is registered:
  - sync_soft at cycle N → tdd_sync at N+1.
  - Timer terminal at N → N+1.
  - External edge first sampled at N → N+3 (2-FF synchronizer plus edge register).
- Shadow copy is visible on outputs one cycle after the qualifying cycle.
- State transitions take effect one cycle after the qualifying condition.
- reset mid-frame: tdd_enable drops the next cycle with no graceful stop; pending config is discarded.

## Configuration
- AXI_TDD_NG_SYNC_EXT_EN defined: external synchronizer and edge path compiled in.
- AXI_TDD_NG_SYNC_EXT_EN undefined: the sync_ext port is kept but ignored, sync_ext_en is ignored, and no synchronizer flops are built.

## Structure
- axi_tdd_ng_pkg gains ctrl_state_t (DISABLED, ARMING, ACTIVE, STOPPING); the existing state_t is reused.
- Sub-module axi_tdd_ng_sync_edge: 2-FF synchronizer plus rising-edge pulse. Instantiated only under AXI_TDD_NG_SYNC_EXT_EN.

## Test plan
- Enable and sync: sw_enable=1, tdd_cstate driven ARMED → ACTIVE two cycles later; sync_soft → one tdd_sync pulse next cycle.
- Internal timer: sync_period=10, sync_int_en=1, ACTIVE, counter ARMED → tdd_sync every 10 cycles; sync_period=0 → none.
- Graceful stop: sw_enable=0 while RUNNING → STOPPING and tdd_enable stays 1; tdd_endof_frame=1 → tdd_enable 0 next cycle.
- Config gating: cfg_update with frame_length=100 while RUNNING → shadow unchanged and cfg_pending=1; once ARMED → shadow=100 and cfg_pending=0; sync requested that cycle → sync_missed.
- Dropped sync: sync_soft while tdd_cstate==RUNNING → no tdd_sync, sync_missed pulses once.
- External path: sync_ext rises (macro defined) → tdd_sync 3 cycles later; level held high → single pulse; macro undefined → no pulse.
